// File: rtl/reg8file_pkg.sv
// rtl/reg8file_pkg.sv - shared types and constants for the reg8file arbiter
//
// Purpose: FSM state encoding, register-file geometry and grant-owner
// encoding shared by the arbiter top and its round-robin picker.
package reg8file_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int RF_DW   = 8;
  localparam int RF_AW   = 3;
  localparam int RF_NREG = 8;
  // Register-file select ports are one bit wider than the address.
  localparam int RF_SW   = 4;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin pick
//
// Purpose: choose between requesters A and B. On a tie the requester that
// was not granted last wins; a lone request wins regardless of history.
// Ports:
//   req_a, req_b  in  request lines
//   last          in  most recently granted owner (OWN_A / OWN_B)
//   gnt_valid     out at least one request is present
//   gnt_owner     out winning owner (OWN_A / OWN_B)
import reg8file_pkg::*;

module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_owner
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_owner = OWN_A;
    if (req_a && req_b) begin
      gnt_owner = (last == OWN_A) ? OWN_B : OWN_A;
    end else if (req_b) begin
      gnt_owner = OWN_B;
    end
  end

endmodule

// File: rtl/reg8file_arbiter.sv
// rtl/reg8file_arbiter.sv - two-port round-robin sequencer for the reg8file
//
// Purpose: shares the register file's single write and read port between
// requesters A and B. A granted request is latched, driven to the register
// file for one SERVE cycle, then acknowledged in the ACK cycle.
// Ports:
//   clk, clr                      clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata     requester A transaction
//   b_req/b_we/b_addr/b_wdata     requester B transaction
//   a_ack, b_ack                  one-cycle completion pulses
//   a_rdata, b_rdata              per-requester read result registers
//   rf_wsel/rf_en/rf_d            register-file write port
//   rf_rsel/rf_q                  register-file read port
//   busy                          FSM is not IDLE
import reg8file_pkg::*;

module reg8file_arbiter #(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_wdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_wdata,
  output logic             a_ack,
  output logic             b_ack,
  output logic [DW-1:0]    a_rdata,
  output logic [DW-1:0]    b_rdata,
  output logic [RF_SW-1:0] rf_wsel,
  output logic             rf_en,
  output logic [DW-1:0]    rf_d,
  output logic [RF_SW-1:0] rf_rsel,
  input  logic [DW-1:0]    rf_q,
  output logic             busy
);

  state_t        state_q, state_d;
  logic          last_q;
  logic          own_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic gnt_valid;
  logic gnt_owner;

  rr_arb2 u_rr_arb2 (
    .req_a     (a_req),
    .req_b     (b_req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    rf_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        // Gating with clr keeps a reset cycle from committing the write.
        rf_en   = we_q & clr;
        state_d = ACK;
      end
      ACK: begin
        a_ack   = (own_q == OWN_A);
        b_ack   = (own_q == OWN_B);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, round-robin history and read-result registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      last_q  <= OWN_B;
      own_q   <= OWN_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        last_q  <= gnt_owner;
        own_q   <= gnt_owner;
        we_q    <= (gnt_owner == OWN_B) ? b_we    : a_we;
        addr_q  <= (gnt_owner == OWN_B) ? b_addr  : a_addr;
        wdata_q <= (gnt_owner == OWN_B) ? b_wdata : a_wdata;
      end
      if (state_q == SERVE && !we_q) begin
        if (own_q == OWN_A) begin
          a_rdata <= rf_q;
        end else begin
          b_rdata <= rf_q;
        end
      end
    end
  end

  // Select and data lines simply follow the latch, so they hold the last
  // granted request outside SERVE.
  assign rf_wsel = RF_SW'(addr_q);
  assign rf_rsel = RF_SW'(addr_q);
  assign rf_d    = wdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/reg8file_arbiter.md
# reg8file_arbiter

Two-port round-robin arbiter and sequencer that shares the 8×8-bit register file's single write port and single read port between two requesters, A and B. Each requester issues one read or write transaction at a time over a req/ack handshake. The block latches the winning request, drives the register file for one cycle, and returns an ack (plus read data for reads). It sits directly in front of `reg8file`, and is the only agent that drives `wsel`, `en`, `d` and `rsel`.

## Interface
- `DW`, default 8: data width; must match the register-file width.
- `AW`, default 3: register address width; 8 registers.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `clr`  in  1: reset; synchronous, active-low.
- `a_req`, `b_req`  in  1: transaction request; held high until ack.
- `a_we`, `b_we`  in  1: 1 = write, 0 = read.
- `a_addr`, `b_addr`  in  AW: target register.
- `a_wdata`, `b_wdata`  in  DW: write data.
- `a_ack`, `b_ack`  out  1: one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  DW: read result; valid with ack and held until that requester's next read completes.
- `rf_wsel`  out  4: register-file write select, `{1'b0, addr}`.
- `rf_en`  out  1: register-file write enable.
- `rf_d`  out  DW: register-file write data.
- `rf_rsel`  out  4: register-file read select, `{1'b0, addr}`.
- `rf_q`  in  DW: register-file combinational read data.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE → SERVE → ACK → IDLE. There are no other transitions.
- **IDLE:**
  - If any request is high, pick a winner by round-robin.
  - Latch the winner's `we`, `addr` and `wdata` into a request register, record the grant owner, and go to SERVE.
  - Otherwise stay in IDLE.
- **Round-robin:**
  - The `last` pointer holds the most recently granted requester.
  - On a tie, grant the requester that is not `last`.
  - With a single request, grant it regardless of `last`.
  - `last` updates on grant. Reset sets `last` = B, so A wins the first tie.
- **SERVE** (exactly one cycle):
  - Drive `rf_wsel`, `rf_rsel` and `rf_d` from the latched request.
  - `rf_en` = latched `we` AND `clr`.
  - For a read, capture `rf_q` into the owner's rdata register at the end of the cycle.
  - Go to ACK.
- **ACK** (exactly one cycle):
  - Assert the owner's ack only. The other ack stays 0.
  - Go to IDLE.
- **Requester rule:** drop `req` (or present a new transaction) in the cycle after ack. Since `req` is only sampled in IDLE, a requester that drops `req` the cycle after ack is never double-granted.
- **Request fields:** changes to `addr`, `wdata` or `we` after grant have no effect; only the latched copy is used.
- **Outside SERVE:** `rf_en` = 0, and `rf_wsel`, `rf_rsel`, `rf_d` hold the last latched values.
- **Reset** (`clr` = 0 at an edge):
  - State → IDLE, `last` → B.
  - acks → 0, `a_rdata` and `b_rdata` → 0, `busy` → 0.
  - `rf_en` → 0, `rf_wsel`/`rf_rsel`/`rf_d` → 0.
  - Reset mid-transaction aborts it with no ack. A write in SERVE during a reset cycle is suppressed (`rf_en` is gated by `clr`).
  - Register-file contents are not cleared by this block.

## Timing
- Request sampled high in IDLE at cycle 0 → SERVE in cycle 1 → ack high in cycle 2.
- Write: register-file contents update at the end of cycle 1. Read data appears on `rdata` in cycle 2, together with ack.
- Throughput: one transaction per 3 cycles. Back-to-back requests from both sides alternate A, B, A, …
- Read-after-write (either requester) returns the new value, because transactions never overlap.
- Worst-case wait for a requester is 3 cycles, assuming the other side follows the requester rule.
- `busy` is high in cycles 1–2 of each transaction.

## Structure
- Shared package `reg8file_pkg`:
  - state enum `{IDLE, SERVE, ACK}`.
  - constants `RF_DW` = 8, `RF_AW` = 3, `RF_NREG` = 8.
  - owner encoding `OWN_A` = 0, `OWN_B` = 1.
- One sub-module, `rr_arb2`: 2-way round-robin pick.
  - Inputs: `req_a`, `req_b`, `last`.
  - Outputs: `gnt_valid`, `gnt_owner`.
  - Purely combinational. The `last` register stays in the parent.
- Top level: FSM, request latch, two rdata registers, and the register-file drive logic.

## Test plan
- Reset, then A writes 0x5A to reg 3 → `rf_en` = 1 with `rf_wsel` = 3 and `rf_d` = 0x5A in cycle 1; `a_ack` in cycle 2; `busy` high in cycles 1–2.
- A reads reg 3 after that write → `a_ack` in cycle 2 with `a_rdata` = 0x5A; `b_rdata` unchanged (0).
- A and B request simultaneously after reset (A writes 0x11 to r1, B reads r1) → A is served first; B's read then returns 0x11; `last` = B afterwards.
- Both requesters hold continuous requests for 4 transactions → grant order A, B, A, B; acks in cycles 2, 5, 8, 11; no double ack.
- Reset is asserted while in SERVE with a pending write of 0xFF to r7 → `rf_en` = 0 in that cycle, no ack, r7 keeps its old value, FSM is in IDLE the next cycle.
- A changes `a_addr` from 2 to 5 in cycle 1 after its grant → `rf_rsel` stays 2 and data from r2 is returned.
